// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants and types for the RAM-backed streaming FIFO controller.
package ram_fifo_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  localparam logic [1:0] RAM_EN_ON  = 2'b11;
  localparam logic [1:0] RAM_EN_OFF = 2'b00;

  // Pointer carries one extra wrap bit above the RAM address.
  typedef logic [ADDR_W:0] ptr_t;

  localparam ptr_t PTR_ZERO = ptr_t'(0);
  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam ptr_t RAM_FULL = ptr_t'(DEPTH);

  // Occupancy of the RAM portion; the wrap bit makes full (16) distinct from empty (0).
  function automatic ptr_t ptr_level(input ptr_t wptr, input ptr_t rptr);
    return wptr - rptr;
  endfunction

endpackage

// File: rtl/ram_fifo_ctrl_skid2.sv
// Two-entry output buffer holding words already read out of the RAM.
// Entry 0 is always the head, so the head is a plain register output.
module fifo_skid2
  import ram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        cnt,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] r_e0;
  logic [DATA_W-1:0] r_e1;
  logic [1:0]        r_cnt;

  // Buffer storage and count; push never arrives while full without a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e0  <= {DATA_W{1'b0}};
      r_e1  <= {DATA_W{1'b0}};
      r_cnt <= 2'd0;
    end else if (flush) begin
      r_cnt <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_e0 <= push_data;
          end else begin
            r_e1 <= push_data;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_e0  <= r_e1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_e0 <= push_data;
          end else begin
            r_e0 <= r_e1;
            r_e1 <= push_data;
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign cnt  = r_cnt;
  assign head = r_e0;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Show-ahead valid/ready FIFO built on port 0 of a 16x16 dual-port RAM with
// registered read data. A 2-entry output buffer absorbs the read latency so the
// consumer sees one word per cycle.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [4:0]        level,
  output logic [1:0]        ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [1:0]        ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data
);

  ptr_t        r_wptr;
  ptr_t        r_rptr;
  logic        r_inflight;

  ptr_t        w_ram_lvl;
  logic [1:0]  w_buf_cnt;
  logic [2:0]  w_proj;
  logic        w_in_ready;
  logic        w_push;
  logic        w_pop;
  logic        w_issue;
  logic        w_capture;

  assign w_ram_lvl  = ptr_level(r_wptr, r_rptr);
  assign w_in_ready = (w_ram_lvl != RAM_FULL) && !flush;
  assign w_push     = in_valid && w_in_ready;
  assign w_pop      = (w_buf_cnt != 2'd0) && out_ready;

  // Buffer slots that will be committed after this edge; a read is only
  // issued when its data is guaranteed a free slot on arrival.
  assign w_proj  = {1'b0, w_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (w_ram_lvl != PTR_ZERO) && (w_proj < 3'd2) && !flush;

  // A flush drops any word returning from the RAM this cycle.
  assign w_capture = r_inflight && !flush;

  // Pointer and in-flight tracking; flush returns everything to empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= PTR_ZERO;
      r_rptr     <= PTR_ZERO;
      r_inflight <= 1'b0;
    end else if (flush) begin
      r_wptr     <= PTR_ZERO;
      r_rptr     <= PTR_ZERO;
      r_inflight <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_issue) begin
        r_rptr <= r_rptr + PTR_ONE;
      end else begin
        r_rptr <= r_rptr;
      end
      r_inflight <= w_issue;
    end
  end

  // RAM write port: driven only for an accepted word, idle at zero otherwise.
  always_comb begin
    ram_wr_en   = RAM_EN_OFF;
    ram_wr_addr = {ADDR_W{1'b0}};
    ram_wr_data = {DATA_W{1'b0}};
    if (w_push) begin
      ram_wr_en   = RAM_EN_ON;
      ram_wr_addr = r_wptr[ADDR_W-1:0];
      ram_wr_data = in_data;
    end else begin
      ram_wr_en   = RAM_EN_OFF;
    end
  end

  // RAM read port: driven only when a read is issued, idle at zero otherwise.
  always_comb begin
    ram_rd_en   = RAM_EN_OFF;
    ram_rd_addr = {ADDR_W{1'b0}};
    if (w_issue) begin
      ram_rd_en   = RAM_EN_ON;
      ram_rd_addr = r_rptr[ADDR_W-1:0];
    end else begin
      ram_rd_en   = RAM_EN_OFF;
    end
  end

  fifo_skid2 u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (w_capture),
    .push_data (ram_rd_data),
    .pop       (w_pop),
    .cnt       (w_buf_cnt),
    .head      (out_data)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = (w_buf_cnt != 2'd0);
  assign level     = w_ram_lvl + {4'b0000, r_inflight} + {3'b000, w_buf_cnt};

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: includes a behavioural 16x16 RAM with
// registered reads, a per-cycle queue-based reference model, a vector table for
// the first transactions and flush, and directed/random sequences.
module tb_ram_fifo_ctrl;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [4:0]  level;
  logic [1:0]  ram_wr_en;
  logic [3:0]  ram_wr_addr;
  logic [15:0] ram_wr_data;
  logic [1:0]  ram_rd_en;
  logic [3:0]  ram_rd_addr;
  logic [15:0] ram_rd_data;

  ram_fifo_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM port 0: synchronous write, registered read.
  logic [15:0] ram_mem [16];
  always @(posedge clk) begin
    if (ram_wr_en == 2'b11) ram_mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en == 2'b11) ram_rd_data <= ram_mem[ram_rd_addr];
  end

  int n_vec = 0;
  int n_bad = 0;
  int cyc_cnt = 0;

  logic [15:0] q[$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data  = 16'h0000;

  logic        s_acc, s_pop, s_ir, s_ov;
  logic [15:0] s_od;
  logic [4:0]  s_lvl;
  logic [1:0]  s_wen, s_ren;
  logic [3:0]  s_wa, s_ra;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, check against the queue model,
  // let the rising edge happen, update the model, return at the next falling edge.
  task automatic cyc(input logic fl, input logic iv, input logic [15:0] id, input logic ordy);
    logic acc, pp;
    flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    acc = in_valid && in_ready;
    pp  = out_valid && out_ready && !fl;
    chk("level", 32'(level), 32'(q.size()));
    chk("wr_en", 32'(ram_wr_en), acc ? 32'h3 : 32'h0);
    if (acc) chk("wr_data", 32'(ram_wr_data), 32'(id));
    if (out_valid) begin
      if (q.size() == 0) chk("valid_when_empty", 32'(out_valid), 32'h0);
      else               chk("head", 32'(out_data), 32'(q[0]));
    end
    if (fl) begin
      chk("flush_in_ready", 32'(in_ready), 32'h0);
      chk("flush_rd_en", 32'(ram_rd_en), 32'h0);
    end else if (q.size() < 16) begin
      chk("in_ready_room", 32'(in_ready), 32'h1);
    end
    if (q.size() == 18) chk("full_in_ready", 32'(in_ready), 32'h0);
    if (prev_stall) begin
      chk("stall_valid", 32'(out_valid), 32'h1);
      chk("stall_data", 32'(out_data), 32'(prev_data));
    end
    s_acc = acc; s_pop = pp; s_ir = in_ready; s_ov = out_valid; s_od = out_data;
    s_lvl = level; s_wen = ram_wr_en; s_ren = ram_rd_en; s_wa = ram_wr_addr; s_ra = ram_rd_addr;
    prev_stall = out_valid && !out_ready && !fl;
    prev_data  = out_data;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(id);
    end
    @(negedge clk);
    cyc_cnt++;
  endtask

  typedef struct {
    logic fl; logic iv; logic [15:0] id; logic ordy;
    logic e_ir; logic e_ov; logic [15:0] e_od; logic chk_od;
    logic [4:0] e_lvl; logic [1:0] e_wen; logic [3:0] e_wa;
    logic [1:0] e_ren; logic [3:0] e_ra;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int k, guard, first, last, npop, base;
    logic [15:0] got;

    tbl[0] = '{1'b0, 1'b1, 16'h1111, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 5'd0, 2'b11, 4'd0, 2'b00, 4'd0};
    tbl[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 5'd1, 2'b00, 4'd0, 2'b11, 4'd0};
    tbl[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 5'd1, 2'b00, 4'd0, 2'b00, 4'd0};
    tbl[3] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1111, 1'b1, 5'd1, 2'b00, 4'd0, 2'b00, 4'd0};
    tbl[4] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 5'd0, 2'b00, 4'd0, 2'b00, 4'd0};
    tbl[5] = '{1'b0, 1'b1, 16'h2222, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 5'd0, 2'b11, 4'd1, 2'b00, 4'd0};
    tbl[6] = '{1'b0, 1'b1, 16'h3333, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 5'd1, 2'b11, 4'd2, 2'b11, 4'd1};
    tbl[7] = '{1'b1, 1'b1, 16'h4444, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 5'd2, 2'b00, 4'd0, 2'b00, 4'd0};
    tbl[8] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 5'd0, 2'b00, 4'd0, 2'b00, 4'd0};
    tbl[9] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 5'd0, 2'b00, 4'd0, 2'b00, 4'd0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_wr_en", 32'(ram_wr_en), 32'h0);
    chk("rst_rd_en", 32'(ram_rd_en), 32'h0);
    chk("rst_wr_addr", 32'(ram_wr_addr), 32'h0);
    chk("rst_rd_addr", 32'(ram_rd_addr), 32'h0);
    chk("rst_wr_data", 32'(ram_wr_data), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // First transaction latency and a flush with a read in flight.
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].fl, tbl[i].iv, tbl[i].id, tbl[i].ordy);
      chk($sformatf("tbl%0d_in_ready", i), 32'(s_ir), 32'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_out_valid", i), 32'(s_ov), 32'(tbl[i].e_ov));
      if (tbl[i].chk_od) chk($sformatf("tbl%0d_out_data", i), 32'(s_od), 32'(tbl[i].e_od));
      chk($sformatf("tbl%0d_level", i), 32'(s_lvl), 32'(tbl[i].e_lvl));
      chk($sformatf("tbl%0d_wr_en", i), 32'(s_wen), 32'(tbl[i].e_wen));
      if (tbl[i].e_wen == 2'b11) chk($sformatf("tbl%0d_wr_addr", i), 32'(s_wa), 32'(tbl[i].e_wa));
      chk($sformatf("tbl%0d_rd_en", i), 32'(s_ren), 32'(tbl[i].e_ren));
      if (tbl[i].e_ren == 2'b11) chk($sformatf("tbl%0d_rd_addr", i), 32'(s_ra), 32'(tbl[i].e_ra));
    end

    // Streaming: 40 words with out_ready high, one out per cycle after the fill.
    first = -1; last = -1; npop = 0; k = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1'b0, (i < 40), 16'h0100 + 16'(i), 1'b1);
      if (s_acc) k++;
      if (s_pop) begin
        if (first < 0) first = i;
        last = i;
        npop++;
      end
    end
    chk("stream_accepted", 32'(k), 32'd40);
    chk("stream_pops", 32'(npop), 32'd40);
    chk("stream_first_pop", 32'(first), 32'd3);
    chk("stream_span", 32'(last - first), 32'd39);

    // Fill to the full 18-word capacity with the consumer stalled, then drain.
    k = 0; guard = 0;
    while (k < 18 && guard < 60) begin
      cyc(1'b0, 1'b1, 16'(k), 1'b0);
      if (s_acc) k++;
      guard++;
    end
    chk("fill_accepted", 32'(k), 32'd18);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 16'hDEAD, 1'b0);
    chk("fill_level", 32'(s_lvl), 32'd18);
    chk("fill_in_ready", 32'(s_ir), 32'h0);
    k = 0;
    for (int i = 0; i < 25; i++) begin
      cyc(1'b0, 1'b0, 16'h0000, 1'b1);
      if (s_pop) begin
        chk("drain_order", 32'(s_od), 32'(k));
        k++;
      end
    end
    chk("drain_count", 32'(k), 32'd18);
    chk("drain_out_valid", 32'(out_valid), 32'h0);

    // Flush at level 10 with a read in flight; a later word must come out first.
    for (int i = 0; i < 11; i++) cyc(1'b0, 1'b1, 16'h0A00 + 16'(i), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("flush_setup_issue", 32'(s_ren), 32'h3);
    cyc(1'b1, 1'b0, 16'h0000, 1'b0);
    chk("flush_level_before", 32'(s_lvl), 32'd10);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("flush_level_after", 32'(s_lvl), 32'd0);
    chk("flush_out_valid", 32'(s_ov), 32'h0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0);
    chk("flush_no_stale", 32'(s_ov), 32'h0);
    cyc(1'b0, 1'b1, 16'hBEEF, 1'b1);
    got = 16'h0000; guard = 0;
    while (!s_pop && guard < 10) begin
      cyc(1'b0, 1'b0, 16'h0000, 1'b1);
      guard++;
    end
    if (s_pop) got = s_od;
    chk("flush_beef_first", 32'(got), 32'hBEEF);

    // Random producer/consumer traffic against the queue model.
    k = 0; guard = 0;
    while (k < 500 && guard < 5000) begin
      cyc(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
      if (s_acc) k++;
      guard++;
    end
    chk("rand_accepted", 32'(k), 32'd500);
    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      cyc(1'b0, 1'b0, 16'h0000, 1'($urandom_range(0, 1)));
      guard++;
    end
    chk("rand_drained", 32'(q.size()), 32'd0);

    // Reset mid-stream at level 5 with a read in flight.
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 16'h5000 + 16'(i), 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b1);
    chk("rst_mid_issue", 32'(s_ren), 32'h3);
    chk("rst_mid_level", 32'(level), 32'd5);
    in_valid = 1'b0; out_ready = 1'b0; in_data = 16'h0000;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'h0);
    chk("rst_mid_out_data", 32'(out_data), 32'h0);
    chk("rst_mid_level0", 32'(level), 32'h0);
    chk("rst_mid_rd_en", 32'(ram_rd_en), 32'h0);
    chk("rst_mid_wr_en", 32'(ram_wr_en), 32'h0);
    q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 16'hA5A5, 1'b1);
    npop = 0; got = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 16'h0000, 1'b1);
      if (s_pop) begin
        npop++;
        got = s_od;
      end
    end
    chk("rst_after_pops", 32'(npop), 32'd1);
    chk("rst_after_data", 32'(got), 32'hA5A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
